mips_regfile_mp: RTL and testbench

//   Parametrised multi-port register file for the pipelined MIPS core, with a
//   per-register pending-write scoreboard and an optional same-cycle write->read

---
 rtl/mips_regfile_mp.sv | 95 +++++++++
 tb/tb_mips_regfile_mp.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file with pending-write scoreboard.
// Optional same-cycle write->read bypass when RF_BYPASS_EN is defined.
module mips_regfile_mp #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int NUM_RD  = 3,
   parameter int DBG_REG = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   output logic [NUM_RD-1:0]    rd_busy,
   input  logic [1:0]           we,
   input  logic [2*AW-1:0]      wa,
   input  logic [2*DW-1:0]      wd,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_addr,
   output logic [DW-1:0]        dbg_data
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0]    regs [DEPTH];
   logic [DEPTH-1:0] busy;

   logic [AW-1:0] wa0, wa1;
   logic [DW-1:0] wd0, wd1;

   assign wa0 = wa[0 +: AW];
   assign wa1 = wa[AW +: AW];
   assign wd0 = wd[0 +: DW];
   assign wd1 = wd[DW +: DW];

   // Register 0 is only ever written by reset, so it stays zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
         busy <= '0;
      end else begin
         for (int unsigned r = 1; r < DEPTH; r++) begin
            logic hit0, hit1, set;
            hit0 = we[0] && (wa0 == AW'(r));
            hit1 = we[1] && (wa1 == AW'(r));
            set  = iss_valid && (iss_addr == AW'(r));
            if (hit1)      regs[r] <= wd1;
            else if (hit0) regs[r] <= wd0;
            if (set)               busy[r] <= 1'b1;
            else if (hit0 || hit1) busy[r] <= 1'b0;
         end
         busy[0] <= 1'b0;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         logic          b;
         a = rd_addr[k*AW +: AW];
         d = regs[a];
         b = busy[a];
`ifdef RF_BYPASS_EN
         // W1 checked last so it overrides W0; a same-cycle issue keeps the register busy.
         if (a != '0) begin
            if (we[0] && wa0 == a) begin
               d = wd0;
               b = iss_valid && (iss_addr == a);
            end
            if (we[1] && wa1 == a) begin
               d = wd1;
               b = iss_valid && (iss_addr == a);
            end
         end
`endif
         if (a == '0) begin
            d = '0;
            b = 1'b0;
         end
         rd_data[k*DW +: DW] = d;
         rd_busy[k]          = b;
      end
   end

   generate
      if (DBG_REG < DEPTH) begin : g_dbg
         assign dbg_data = regs[DBG_REG];
      end else begin : g_dbg_off
         assign dbg_data = '0;
      end
   endgenerate

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed self-checking bench for mips_regfile_mp (default parameters).
module tb_mips_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_busy;
   logic [1:0]        we;
   logic [2*AW-1:0]   wa;
   logic [2*DW-1:0]   wd;
   logic              iss_valid;
   logic [AW-1:0]     iss_addr;
   logic [DW-1:0]     dbg_data;

   int tests = 0;
   int fails = 0;

   mips_regfile_mp #(.DW(DW), .AW(AW), .NUM_RD(NR), .DBG_REG(11)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
      .iss_addr(iss_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int k, input logic [AW-1:0] a);
      rd_addr[k*AW +: AW] = a;
   endtask

   function automatic logic [DW-1:0] rdd(input int k);
      return rd_data[k*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] rdb(input int k);
      return {31'b0, rd_busy[k]};
   endfunction

   task automatic wr(input logic [1:0] e, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      we = e;
      wa = {a1, a0};
      wd = {d1, d0};
   endtask

   task automatic idle();
      we = 2'b00;
      iss_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; rd_addr = '0; we = '0; wa = '0; wd = '0;
      iss_valid = 1'b0; iss_addr = '0;
      tick();
      reset = 1'b0;

      // 1: reset state
      for (int a = 0; a < 32; a++) begin
         set_rd(0, AW'(a));
         #1;
         check($sformatf("rst_data[%0d]", a), rdd(0), 32'h0);
         check($sformatf("rst_busy[%0d]", a), rdb(0), 32'h0);
      end
      check("rst_dbg", dbg_data, 32'h0);

      // 2: basic write, register 0 hardwired
      wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
      tick(); idle(); set_rd(0, 5'd5); #1;
      check("wr5", rdd(0), 32'hDEADBEEF);
      wr(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0);
      iss_valid = 1'b1; iss_addr = 5'd0;
      tick(); idle(); set_rd(0, 5'd0); #1;
      check("r0_data", rdd(0), 32'h0);
      check("r0_busy", rdb(0), 32'h0);

      // 3: dual write same address -> W1 wins; different addresses both commit
      wr(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222);
      tick(); idle(); set_rd(0, 5'd7); #1;
      check("dual_same", rdd(0), 32'h2222);
      wr(2'b11, 5'd20, 32'hA0A0, 5'd21, 32'hB1B1);
      tick(); idle(); set_rd(0, 5'd20); set_rd(1, 5'd21); #1;
      check("dual_w0", rdd(0), 32'hA0A0);
      check("dual_w1", rdd(1), 32'hB1B1);

      // 4: scoreboard
      iss_valid = 1'b1; iss_addr = 5'd9;
      tick(); idle(); set_rd(2, 5'd9); #1;
      check("busy_set", rdb(2), 32'h1);
      wr(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
      iss_valid = 1'b1; iss_addr = 5'd9;
      tick(); idle(); #1;
      check("busy_setclr", rdb(2), 32'h1);
      check("data_setclr", rdd(2), 32'h99);
      wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h9A);
      tick(); idle(); #1;
      check("busy_clr", rdb(2), 32'h0);
      check("data_clr", rdd(2), 32'h9A);

      // 5: same-cycle bypass
      set_rd(1, 5'd12);
      wr(2'b01, 5'd12, 32'hA5A5A5A5, 5'd0, 32'h0);
      #1;
`ifdef RF_BYPASS_EN
      check("byp_data", rdd(1), 32'hA5A5A5A5);
`else
      check("byp_data", rdd(1), 32'h0);
`endif
      check("byp_busy", rdb(1), 32'h0);
      tick(); idle(); #1;
      check("byp_next", rdd(1), 32'hA5A5A5A5);

      // 6: reset drops pending busy state and discards same-cycle writes
      wr(2'b01, 5'd11, 32'h55, 5'd0, 32'h0);
      tick(); idle();
      iss_valid = 1'b1; iss_addr = 5'd3;
      tick();
      iss_valid = 1'b1; iss_addr = 5'd11;
      tick(); idle(); set_rd(0, 5'd3); set_rd(1, 5'd11); #1;
      check("pre_busy3", rdb(0), 32'h1);
      check("pre_busy11", rdb(1), 32'h1);
      check("pre_dbg", dbg_data, 32'h55);
      reset = 1'b1;
      wr(2'b01, 5'd3, 32'h77, 5'd0, 32'h0);
      iss_valid = 1'b1; iss_addr = 5'd3;
      tick();
      reset = 1'b0; idle(); #1;
      check("post_busy3", rdb(0), 32'h0);
      check("post_busy11", rdb(1), 32'h0);
      check("post_r3", rdd(0), 32'h0);
      check("post_r11", rdd(1), 32'h0);
      check("post_dbg", dbg_data, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
